trigger_capture: RTL and testbench



---
 rtl/trigger_capture.sv | 246 ++++++++++++++++++++++++
 tb/tb_trigger_capture.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// trigger_capture: a small logic-analyzer capture engine.
// Once armed, it waits for a pattern match or an edge on the synchronized
// trigger channels. It then records CAPTURE_LEN consecutive samples of the
// synchronized data channels into an internal buffer, starting with the
// trigger cycle. The buffer is drained oldest-first through a pop-style read
// port once the capture is DONE.
//
// Read handshake: rd_en is a request with no back-pressure. A request is
// accepted only in DONE with count > 0 and no arm in the same cycle. Each
// accepted request produces exactly one rd_valid pulse on the next cycle, and
// rd_data is valid with that pulse. Requests that are not accepted are
// dropped without side effects. rd_data keeps its last value between pulses.

module trigger_capture #(
  parameter int TRIG_W      = 3,
  parameter int DATA_W      = 2,
  parameter int CAPTURE_LEN = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arm,
  input  logic                             mode,
  input  logic [TRIG_W-1:0]                trig_mask,
  input  logic [TRIG_W-1:0]                trig_value,
  input  logic [$clog2(TRIG_W)-1:0]        edge_sel,
  input  logic                             edge_pol,
  input  logic [TRIG_W-1:0]                trig_in,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             rd_en,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic                             armed,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(CAPTURE_LEN+1)-1:0] count
);

  localparam int SEL_W = $clog2(TRIG_W);
  localparam int CNT_W = $clog2(CAPTURE_LEN + 1);
  localparam int PTR_W = $clog2(CAPTURE_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [TRIG_W-1:0] r_trig_sync [SYNC_STAGES];
  logic [DATA_W-1:0] r_data_sync [SYNC_STAGES];
  logic [TRIG_W-1:0] r_prev_s;
  logic [TRIG_W-1:0] w_trig_s;
  logic [DATA_W-1:0] w_data_s;

  // Shift both channel groups through the same number of stages so that
  // the data sample stays cycle-aligned with the trigger that selects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_trig_sync[i] <= '0;
        r_data_sync[i] <= '0;
      end
    end else begin
      r_trig_sync[0] <= trig_in;
      r_data_sync[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_trig_sync[i] <= r_trig_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  assign w_trig_s = r_trig_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Keep the previous synchronized trigger word in every state, so an edge
  // that began before arming can never look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_s <= '0;
    end else begin
      r_prev_s <= w_trig_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger condition
  // ---------------------------------------------------------------------------
  logic w_cur_bit;
  logic w_prev_bit;
  logic w_pat_hit;
  logic w_edge_hit;
  logic w_cond;

  // Select the watched bit by a compare loop; out-of-range indices select 0.
  always_comb begin
    w_cur_bit  = 1'b0;
    w_prev_bit = 1'b0;
    for (int i = 0; i < TRIG_W; i++) begin
      if (edge_sel == SEL_W'(i)) begin
        w_cur_bit  = w_trig_s[i];
        w_prev_bit = r_prev_s[i];
      end
    end
  end

  assign w_pat_hit  = (((w_trig_s ^ trig_value) & trig_mask) == '0);
  assign w_edge_hit = edge_pol ? (!w_prev_bit &&  w_cur_bit)
                               : ( w_prev_bit && !w_cur_bit);
  assign w_cond     = mode ? w_edge_hit : w_pat_hit;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               w_last_write;
  logic               w_clear;
  logic               w_write;
  logic               w_read;

  // The last write is the one that brings the stored count up to CAPTURE_LEN.
  assign w_last_write = (r_count == CNT_W'(CAPTURE_LEN - 1));

  // Advance the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Choose the next state. arm is only honoured where it can start a new capture.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (w_cond) w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_last_write) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (arm) w_next_state = S_ARMED;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Decode the status outputs and datapath strobes from the current state.
  always_comb begin
    armed   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    w_clear = 1'b0;
    w_write = 1'b0;
    w_read  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear = arm;
      end
      S_ARMED: begin
        armed   = 1'b1;
        w_write = w_cond;
      end
      S_CAPTURE: begin
        busy    = 1'b1;
        w_write = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        w_clear = arm;
        // A re-arm in the same cycle discards the read request.
        w_read  = rd_en && !arm && (r_count != '0);
      end
      default: begin
        w_clear = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------

  // Writes happen only while filling and reads only in DONE, so the two
  // never overlap. Every arm restarts both pointers at index 0, so the
  // pointers never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_write) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count  <= r_count + 1'b1;
    end else if (w_read) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  assign count = r_count;

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_buf [CAPTURE_LEN];

  // The storage has no reset. Stale contents are unreachable because count
  // restarts at 0 on every arm.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_buf[r_wr_ptr] <= w_data_s;
    end
  end

  // Register the popped sample and its one-cycle valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= w_read;
      if (w_read) begin
        rd_data <= r_buf[r_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed and randomized stimulus for trigger_capture.
// A behavioural model keeps the captured samples in a queue, takes the
// synchronizer delay from a short input history, and predicts every output
// on every clock.

module tb_trigger_capture;

  localparam int TRIG_W      = 3;
  localparam int DATA_W      = 2;
  localparam int CAPTURE_LEN = 9;
  localparam int SYNC_STAGES = 2;
  localparam int SEL_W       = $clog2(TRIG_W);
  localparam int CNT_W       = $clog2(CAPTURE_LEN + 1);

  localparam int PH_IDLE    = 0;
  localparam int PH_ARMED   = 1;
  localparam int PH_CAPTURE = 2;
  localparam int PH_DONE    = 3;

  logic              clk;
  logic              rst;
  logic              arm;
  logic              mode;
  logic [TRIG_W-1:0] trig_mask;
  logic [TRIG_W-1:0] trig_value;
  logic [SEL_W-1:0]  edge_sel;
  logic              edge_pol;
  logic [TRIG_W-1:0] trig_in;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              armed;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;

  int n_vec;
  int n_err;

  // Reference model state
  int                m_phase;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic [TRIG_W-1:0] m_trig_hist[$];
  logic [DATA_W-1:0] m_data_hist[$];

  trigger_capture #(
    .TRIG_W(TRIG_W), .DATA_W(DATA_W),
    .CAPTURE_LEN(CAPTURE_LEN), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode),
    .trig_mask(trig_mask), .trig_value(trig_value),
    .edge_sel(edge_sel), .edge_pol(edge_pol),
    .trig_in(trig_in), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .armed(armed), .busy(busy), .done(done), .count(count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Model: back to the reset state. The synchronizer history is all zeros.
  task automatic model_reset();
    m_phase    = PH_IDLE;
    exp_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_trig_hist.delete();
    m_data_hist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      m_trig_hist.push_back('0);
      m_data_hist.push_back('0);
    end
  endtask

  // Model: trigger condition on the synchronized view (index 0 = newest sample).
  function automatic bit model_cond();
    logic [TRIG_W-1:0] ts;
    logic [TRIG_W-1:0] ps;
    ts = m_trig_hist[SYNC_STAGES-1];
    ps = m_trig_hist[SYNC_STAGES];
    if (!mode) return (((ts ^ trig_value) & trig_mask) == '0);
    if (edge_pol) return (!ps[edge_sel] && ts[edge_sel]);
    return (ps[edge_sel] && !ts[edge_sel]);
  endfunction

  // Model: one rising clock edge with the inputs currently driven.
  task automatic model_edge();
    bit                c;
    logic [DATA_W-1:0] ds;
    c  = model_cond();
    ds = m_data_hist[SYNC_STAGES-1];
    m_rd_valid = 1'b0;
    case (m_phase)
      PH_IDLE: if (arm) begin
        m_phase = PH_ARMED;
        exp_q.delete();
      end
      PH_ARMED: if (c) begin
        exp_q.push_back(ds);
        m_phase = PH_CAPTURE;
      end
      PH_CAPTURE: begin
        exp_q.push_back(ds);
        if (exp_q.size() == CAPTURE_LEN) m_phase = PH_DONE;
      end
      default: begin
        if (arm) begin
          m_phase = PH_ARMED;
          exp_q.delete();
        end else if (rd_en && exp_q.size() > 0) begin
          m_rd_data  = exp_q.pop_front();
          m_rd_valid = 1'b1;
        end
      end
    endcase
    m_trig_hist.push_front(trig_in);
    void'(m_trig_hist.pop_back());
    m_data_hist.push_front(data_in);
    void'(m_data_hist.pop_back());
  endtask

  task automatic check_all();
    chk("armed",    32'(armed),    32'(m_phase == PH_ARMED));
    chk("busy",     32'(busy),     32'(m_phase == PH_CAPTURE));
    chk("done",     32'(done),     32'(m_phase == PH_DONE));
    chk("count",    32'(count),    32'(exp_q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    chk("rd_data",  32'(rd_data),  32'(m_rd_data));
  endtask

  // Driver: apply one cycle of inputs, clock, then compare.
  task automatic step(input logic a, input logic r, input logic [TRIG_W-1:0] t,
                      input logic [DATA_W-1:0] d);
    @(negedge clk);
    arm = a; rd_en = r; trig_in = t; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_step(input logic a, input logic r);
    step(a, r, TRIG_W'($urandom), DATA_W'($urandom));
  endtask

  // Reset asserted asynchronously mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    arm = 1'b0; rd_en = 1'b0; trig_in = '0; data_in = '0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_armed",    32'(armed),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Bounded wait for DONE with random trigger/data traffic.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      rand_step(1'b0, 1'b0);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Bounded drain with random read requests.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (count !== '0 && n < 100) begin
      rand_step(1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    chk(tag, 32'(count), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] pat [CAPTURE_LEN];
    logic [DATA_W-1:0] d_fall;
    logic [1:0]        low;
    logic              a;

    n_vec = 0;
    n_err = 0;
    pat = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b0; arm = 1'b0; rd_en = 1'b0; mode = 1'b0;
    trig_mask = '0; trig_value = '0; edge_sel = '0; edge_pol = 1'b0;
    trig_in = '0; data_in = '0;
    model_reset();

    // Reset state
    do_reset();

    // Pattern trigger: mask 111, value 101
    mode = 1'b0; trig_mask = 3'b111; trig_value = 3'b101;
    step(1'b1, 1'b0, 3'b000, DATA_W'($urandom));
    repeat (3) step(1'b0, 1'b0, 3'b000, DATA_W'($urandom));
    chk("pat_armed", 32'(armed), 32'd1);
    for (int i = 0; i < CAPTURE_LEN; i++) begin
      step(1'b0, 1'b0, 3'b101, pat[i]);
      chk("pat_busy_timing", 32'(busy), 32'(i >= SYNC_STAGES));
    end
    repeat (2) step(1'b0, 1'b0, 3'b101, DATA_W'($urandom));
    chk("pat_done", 32'(done), 32'd1);
    chk("pat_count", 32'(count), 32'(CAPTURE_LEN));
    for (int i = 0; i < CAPTURE_LEN; i++) begin
      rand_step(1'b0, 1'b1);
      chk("pat_rd_valid", 32'(rd_valid), 32'd1);
      chk("pat_rd_data", 32'(rd_data), 32'(pat[i]));
    end

    // Over-read: requests with an empty buffer
    repeat (3) begin
      rand_step(1'b0, 1'b1);
      chk("over_rd_valid", 32'(rd_valid), 32'd0);
      chk("over_count", 32'(count), 32'd0);
      chk("over_rd_data", 32'(rd_data), 32'(pat[CAPTURE_LEN-1]));
    end

    // Edge trigger: falling edge on bit 2; a rising edge must not trigger
    mode = 1'b1; edge_sel = 2'd2; edge_pol = 1'b0;
    repeat (3) step(1'b0, 1'b0, {1'b0, 2'($urandom)}, DATA_W'($urandom));
    step(1'b1, 1'b0, {1'b0, 2'($urandom)}, DATA_W'($urandom));
    repeat (3) step(1'b0, 1'b0, {1'b0, 2'($urandom)}, DATA_W'($urandom));
    chk("edge_armed", 32'(armed), 32'd1);
    for (int i = 0; i < 6; i++) begin
      low = 2'($urandom);
      step(1'b0, 1'b0, {1'b1, low}, DATA_W'($urandom));
      chk("edge_rise_no_trig", 32'(busy), 32'd0);
    end
    d_fall = DATA_W'($urandom);
    step(1'b0, 1'b0, {1'b0, 2'($urandom)}, d_fall);
    chk("edge_fall_wait0", 32'(busy), 32'd0);
    step(1'b0, 1'b0, {1'b0, 2'($urandom)}, DATA_W'($urandom));
    chk("edge_fall_wait1", 32'(busy), 32'd0);
    step(1'b0, 1'b0, {1'b0, 2'($urandom)}, DATA_W'($urandom));
    chk("edge_fall_busy", 32'(busy), 32'd1);
    wait_done("edge_wait_done", 20);
    rand_step(1'b0, 1'b1);
    chk("edge_first_sample", 32'(rd_data), 32'(d_fall));
    drain("edge_drain");

    // Mask zero: trigger on the first ARMED cycle; arm ignored while capturing
    mode = 1'b0; trig_mask = 3'b000;
    rand_step(1'b1, 1'b0);
    chk("mask0_armed", 32'(armed), 32'd1);
    rand_step(1'b0, 1'b0);
    chk("mask0_busy", 32'(busy), 32'd1);
    for (int i = 0; i < CAPTURE_LEN - 1; i++) begin
      rand_step(1'(i == 3), 1'b0);
    end
    chk("mask0_done", 32'(done), 32'd1);
    chk("mask0_count", 32'(count), 32'(CAPTURE_LEN));

    // Four reads, then re-arm together with a read request
    repeat (4) rand_step(1'b0, 1'b1);
    chk("rearm_pre_count", 32'(count), 32'(CAPTURE_LEN - 4));
    rand_step(1'b1, 1'b1);
    chk("rearm_rd_valid", 32'(rd_valid), 32'd0);
    chk("rearm_count", 32'(count), 32'd0);
    chk("rearm_armed", 32'(armed), 32'd1);
    wait_done("rearm_wait_done", 20);
    drain("rearm_drain");

    // Reset in the middle of a capture
    trig_mask = 3'b000;
    rand_step(1'b1, 1'b0);
    rand_step(1'b0, 1'b0);
    repeat (3) rand_step(1'b0, 1'b0);
    chk("midcap_count", 32'(count), 32'd4);
    do_reset();
    repeat (3) begin
      rand_step(1'b0, 1'b1);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
    end

    // Random traffic; configuration changes only while idle or done
    for (int i = 0; i < 600; i++) begin
      a = 1'($urandom_range(0, 11) == 0);
      if ((m_phase == PH_IDLE || m_phase == PH_DONE) && !a && $urandom_range(0, 3) == 0) begin
        mode       = 1'($urandom);
        trig_mask  = TRIG_W'($urandom);
        trig_value = TRIG_W'($urandom);
        edge_sel   = SEL_W'($urandom_range(0, TRIG_W - 1));
        edge_pol   = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rand_step(a, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
